// File: rtl/data_ram_write_arbiter.sv
// Data RAM write-port arbiter: core writeback has priority, host writes are
// queued in a small FIFO and drained when the core is idle or when the host
// has been starved for STARVE_LIMIT consecutive cycles.
module data_ram_write_arbiter #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          iCoreWriteEnable,
   input  logic [ADDR_WIDTH-1:0]         iCoreAddress,
   input  logic [DATA_WIDTH-1:0]         iCoreData,
   output logic                          oCoreStall,
   input  logic                          iHostValid,
   input  logic [ADDR_WIDTH-1:0]         iHostAddress,
   input  logic [DATA_WIDTH-1:0]         iHostData,
   output logic                          oHostReady,
   output logic                          oRamWriteEnable,
   output logic [ADDR_WIDTH-1:0]         oRamWriteAddress,
   output logic [DATA_WIDTH-1:0]         oRamDataIn,
   output logic                          oGrantHost,
   output logic [$clog2(FIFO_DEPTH):0]   oHostPending
);

   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam int unsigned STARVE_W = 8;
   localparam int unsigned ENTRY_W  = ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];

   logic                fifo_empty;
   logic                fifo_full;
   logic                push;
   logic                host_grant;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

   // Arbitration, RAM port mux and next-state computation
   always_comb begin
      fifo_empty = (count_q == CNT_W'(0));
      fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
      push       = iHostValid & ~fifo_full & ~Reset;
      {head_addr, head_data} = mem[rd_ptr_q];
      // FORCE is only ever entered with a non-empty queue; the empty term keeps it safe anyway
      host_grant = ~fifo_empty & ((state_q == FORCE) | ~iCoreWriteEnable) & ~Reset;

      oCoreStall       = (state_q == FORCE) & ~Reset;
      oHostReady       = ~fifo_full & ~Reset;
      oGrantHost       = host_grant;
      oHostPending     = count_q;
      oRamWriteEnable  = 1'b0;
      oRamWriteAddress = '0;
      oRamDataIn       = '0;
      if (host_grant) begin
         oRamWriteEnable  = 1'b1;
         oRamWriteAddress = head_addr;
         oRamDataIn       = head_data;
      end else if (iCoreWriteEnable && (state_q == NORMAL) && !Reset) begin
         oRamWriteEnable  = 1'b1;
         oRamWriteAddress = iCoreAddress;
         oRamDataIn       = iCoreData;
      end

      wr_ptr_d = push       ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = host_grant ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !host_grant)      count_d = count_q + CNT_W'(1);
      else if (!push && host_grant) count_d = count_q - CNT_W'(1);

      state_d  = NORMAL;
      starve_d = '0;
      if ((state_q == NORMAL) && !fifo_empty && iCoreWriteEnable) begin
         starve_d = starve_q + STARVE_W'(1);
         if (starve_d == STARVE_W'(STARVE_LIMIT)) state_d = FORCE;
      end
   end

   // FSM, starve counter and FIFO pointers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= NORMAL;
         starve_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; contents are don't-care until pushed
   always_ff @(posedge Clock) begin
      if (push) mem[wr_ptr_q] <= {iHostAddress, iHostData};
   end

endmodule

// File: doc/data_ram_write_arbiter.md
DATA_RAM_WRITE_ARBITER -- requirements
Module: data_ram_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the RAM data word.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the RAM write address.
REQ-003 Parameter FIFO_DEPTH, default 4: host write queue depth; power of two, at least 2.
REQ-004 Parameter STARVE_LIMIT, default 8: consecutive denied cycles before host gets the port; range 1..255.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port `Clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port `Reset`, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port `iCoreWriteEnable`, input, 1 bit: the pipeline writeback requests the port this cycle.
REQ-009 Port `iCoreAddress`, input, ADDR_WIDTH bits: core write address.
REQ-010 Port `iCoreData`, input, DATA_WIDTH bits: core write data.
REQ-011 Port `oCoreStall`, output, 1 bit: the pipeline SHALL freeze and hold its request this cycle.
REQ-012 Port `iHostValid`, input, 1 bit: the host offers a write.
REQ-013 Port `iHostAddress`, input, ADDR_WIDTH bits: host write address.
REQ-014 Port `iHostData`, input, DATA_WIDTH bits: host write data.
REQ-015 Port `oHostReady`, output, 1 bit: the queue accepts a host write this cycle.
REQ-016 Port `oRamWriteEnable`, output, 1 bit: write enable to the data RAM write port.
REQ-017 Port `oRamWriteAddress`, output, ADDR_WIDTH bits: RAM write address.
REQ-018 Port `oRamDataIn`, output, DATA_WIDTH bits: RAM write data.
REQ-019 Port `oGrantHost`, output, 1 bit: the current RAM write comes from the host queue.
REQ-020 Port `oHostPending`, output, clog2(FIFO_DEPTH)+1 bits: number of queued host writes.

Function
REQ-021 Host push SHALL occur on a rising edge with iHostValid=1 and oHostReady=1; it is captured into the FIFO tail.
REQ-022 oHostReady SHALL be 1 exactly when the FIFO is not full; a pop in the same cycle does not raise it when full.
REQ-023 The FSM SHALL have two states: NORMAL and FORCE.
REQ-024 In NORMAL, if iCoreWriteEnable=1, the RAM port SHALL carry the core request with zero latency (combinational path), and oGrantHost SHALL be 0.
REQ-025 In NORMAL, if iCoreWriteEnable=0 and the FIFO is non-empty, the FIFO head SHALL drive the RAM port with oGrantHost=1, and the head SHALL pop at the clock edge.
REQ-026 In NORMAL, if iCoreWriteEnable=0 and the FIFO is empty, oRamWriteEnable SHALL be 0, and address and data SHALL be 0.
REQ-027 The starve counter SHALL increment each NORMAL cycle with FIFO non-empty and iCoreWriteEnable=1, and SHALL clear on any host grant or when the FIFO is empty.
REQ-028 When the starve counter reaches STARVE_LIMIT, the FSM SHALL enter FORCE on the next edge.
REQ-029 In FORCE, for exactly one cycle: oCoreStall=1, the FIFO head is written with oGrantHost=1 and popped, the counter clears, and the FSM returns to NORMAL.
REQ-030 oCoreStall SHALL be 0 in NORMAL.
REQ-031 A core request present during FORCE SHALL NOT be written that cycle; it is served in the following NORMAL cycle.
REQ-032 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave oHostPending unchanged.
REQ-033 A push to an empty FIFO SHALL become grantable on the next cycle; there is no same-cycle bypass.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 Host writes SHALL retire in FIFO order.
REQ-036 Same-address conflicts between core and host SHALL be resolved only by grant order; there is no merging.

Reset
REQ-037 While Reset=1, all outputs SHALL be 0, including oHostReady, and the FIFO SHALL be empty.
REQ-038 Reset SHALL place the FSM in NORMAL and clear the starve counter.
REQ-039 Reset asserted mid-operation SHALL discard queued host writes.
REQ-040 The first push SHALL be possible on the first rising edge after Reset deasserts.

Verification
REQ-041 Idle core, host pushes (0x10,0xABCD): next cycle oRamWriteEnable=1, address 0x10, data 0xABCD, oGrantHost=1; then oHostPending=0.
REQ-042 Core writes every cycle while the FIFO holds one entry, STARVE_LIMIT=8: after 8 denied cycles there is exactly one cycle with oCoreStall=1 and the host entry written; the held core write follows next cycle.
REQ-043 Four pushes with the core busy: oHostReady=0 at oHostPending=4; a fifth iHostValid is not accepted; entries drain in order once the core idles.
REQ-044 Push and pop in the same cycle with oHostPending=2: the count stays 2.
REQ-045 Reset pulsed asynchronously with oHostPending=3: outputs go to 0 immediately; after release oHostPending=0 and no stale write ever appears.
REQ-046 Core write 0x22 and host write 0x22 in the same cycle: the core value is written first and the host value second, so the final RAM content is the host data.
